// File: rtl/alu_pkg.sv
// Shared ALU definitions used by alu_pipeline, alu_result_buffer and the writeback stage.
package alu_pkg;

  localparam int unsigned ALU_DATA_W   = 8;
  localparam int unsigned ALU_RB_DEPTH = 4;

  typedef logic [ALU_DATA_W-1:0] alu_result_t;

endpackage

// File: rtl/alu_rb_mem.sv
// Result buffer storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking makes stale entries invisible.
module alu_rb_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_buffer.sv
// Elastic FIFO between alu_pipeline and its consumer; drops (and flags) pushes when full.
// Optional even-parity per entry and out_parity port when ALU_RESULT_PARITY_EN is defined.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned DEPTH  = ALU_RB_DEPTH,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow,
`ifdef ALU_RESULT_PARITY_EN
  output logic                     out_parity,
`endif
  output logic [CNT_W-1:0]         accepted_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
`ifdef ALU_RESULT_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned MEM_W = DATA_W + PAR_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  logic             full_c, empty_c, push_c, pop_c, drop_c;
  logic [MEM_W-1:0] wdata_c, rdata_c;

  // Handshake flags depend only on the occupancy register.
  assign full_c  = (count_q == OCC_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = in_valid & ~full_c;
  assign pop_c   = ~empty_c & out_ready;
  assign drop_c  = in_valid & full_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ovf_d    = drop_c | (ovf_q & ~clr_overflow);
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
    // Debug counter saturates instead of wrapping.
    if (push_c && (acc_q != {CNT_W{1'b1}})) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end
  end

`ifdef ALU_RESULT_PARITY_EN
  assign wdata_c    = {^in_data, in_data};
  assign out_parity = rdata_c[DATA_W];
`else
  assign wdata_c    = in_data;
`endif

  alu_rb_mem #(
    .DEPTH (DEPTH),
    .WIDTH (MEM_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_c)
  );

  assign out_data     = rdata_c[DATA_W-1:0];
  assign in_ready     = ~full_c;
  assign out_valid    = ~empty_c;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign accepted_cnt = acc_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed pushes queue expected results, a monitor checks pops.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ACC_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  alu_result_t       in_data = '0;
  logic              in_ready;
  logic              out_valid;
  alu_result_t       out_data;
  logic              out_ready = 1'b0;
  logic [2:0]        count;
  logic              overflow;
  logic              clr_overflow = 1'b0;
  logic [CNT_W-1:0]  accepted_cnt;
`ifdef ALU_RESULT_PARITY_EN
  logic              out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int acc_exp  = 0;
  alu_result_t sb[$];

  alu_result_buffer #(
    .DATA_W (ALU_DATA_W),
    .DEPTH  (ALU_RB_DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity   (out_parity),
`endif
    .accepted_cnt (accepted_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every handshake seen mid-cycle pops one expected value.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0h with empty scoreboard", out_data);
      end else begin
        alu_result_t exp_v;
        exp_v = sb.pop_front();
        if (out_data !== exp_v) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", out_data, exp_v);
        end
      end
`ifdef ALU_RESULT_PARITY_EN
      n_checks++;
      if ((^{out_data, out_parity}) !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_xor: data %0h parity %0b", out_data, out_parity);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and record what the buffer must later emit.
  task automatic drive(input logic v, input alu_result_t d, input logic rdy, input logic accept);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    if (v && accept) begin
      sb.push_back(d);
      if (acc_exp < ACC_MAX) acc_exp++;
    end
    tick();
  endtask

  task automatic pulse_clr();
    in_valid     = 1'b0;
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_empty"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_acc", 32'(accepted_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Three results held, then released in order.
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("t1_count", 32'(count), 32'd3);
    check("t1_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    repeat (3) tick();
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_drained", 32'(sb.size()), 32'd0);
    out_ready = 1'b0;

    // Fill past capacity: fifth push is dropped.
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i), 1'b0, i <= 4);
    in_valid = 1'b0;
    check("t2_count", 32'(count), 32'd4);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_acc", 32'(accepted_cnt), 32'(acc_exp));
    drain("t2");

    // Full push coinciding with a pop is still rejected.
    pulse_clr();
    check("t3_clr0", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
    drive(1'b1, 8'hAA, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3_count", 32'(count), 32'd3);
    check("t3_overflow", 32'(overflow), 32'd1);
    pulse_clr();
    check("t3_clr1", 32'(overflow), 32'd0);
    drive(1'b1, 8'hA5, 1'b0, 1'b1);
    check("t3_full", 32'(count), 32'd4);
    clr_overflow = 1'b1;
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    clr_overflow = 1'b0;
    check("t3_set_wins", 32'(overflow), 32'd1);
    check("t3_acc_sat", 32'(accepted_cnt), 32'(acc_exp));
    pulse_clr();
    check("t3_clr2", 32'(overflow), 32'd0);
    drain("t3");

    // Streaming at full rate wraps the pointers several times.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b1);
      check("t4_count", 32'(count), 32'd1);
    end
    drain("t4");

    // Asynchronous reset mid-stream.
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    drive(1'b1, 8'h66, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("t5_pre_count", 32'(count), 32'd2);
    reset = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_acc", 32'(accepted_cnt), 32'd0);
    sb.delete();
    acc_exp = 0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    drive(1'b1, 8'h7E, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("t5_valid_after", 32'(out_valid), 32'd1);
    check("t5_data_after", 32'(out_data), 32'h7E);
    check("t5_acc_after", 32'(accepted_cnt), 32'(acc_exp));
    drain("t5");

`ifdef ALU_RESULT_PARITY_EN
    drive(1'b1, 8'h07, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("par_07", 32'(out_parity), 32'd1);
    drain("par_07");
    drive(1'b1, 8'h03, 1'b0, 1'b1);
    in_valid = 1'b0;
    check("par_03", 32'(out_parity), 32'd0);
    drain("par_03");
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
